// File: rtl/huffman_decoder.sv
// ---------------------------------------------------------------------------
// huffman_decoder
//
// Receiving end of the Huffman encoder's serial code stream. A codeword table
// (length + right-aligned code per symbol) is loaded first, one entry per
// cycle in symbol order. After that the block accepts a serial MSB-first
// bitstream and emits one decoded symbol index per completed codeword.
//
// Ports:
//   clk        clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   tbl_valid  table-load strobe, high for NSYM consecutive cycles
//   tbl_len    codeword length of the current table entry (1..MAX_LEN)
//   tbl_code   codeword of the current entry, right-aligned
//   in_valid   serial bit strobe
//   in_bit     serial code bit, MSB of each codeword first
//   in_last    marks the final bit of the stream (qualified by in_valid)
//   out_valid  one-cycle pulse, out_sym holds a decoded symbol
//   out_sym    decoded symbol index (zero whenever out_valid is low)
//   out_err    one-cycle pulse, undecodable bits were discarded
//   out_done   one-cycle pulse, stream finished and block back in IDLE
// ---------------------------------------------------------------------------
module huffman_decoder #(
    parameter int NSYM    = 8,
    parameter int SYM_W   = 3,
    parameter int MAX_LEN = 7,
    parameter int LEN_W   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tbl_valid,
    input  logic [LEN_W-1:0]   tbl_len,
    input  logic [MAX_LEN-1:0] tbl_code,
    input  logic               in_valid,
    input  logic               in_bit,
    input  logic               in_last,
    output logic               out_valid,
    output logic [SYM_W-1:0]   out_sym,
    output logic               out_err,
    output logic               out_done
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DECODE
    } state_t;

    state_t             state;
    logic [SYM_W-1:0]   load_cnt;
    logic [LEN_W-1:0]   len_tab  [NSYM];
    logic [MAX_LEN-1:0] code_tab [NSYM];
    logic               table_ok;
    logic [MAX_LEN-1:0] acc;
    logic [LEN_W-1:0]   cnt;

    logic [MAX_LEN-1:0] new_acc;
    logic [LEN_W-1:0]   new_cnt;
    logic [MAX_LEN-1:0] len_mask;
    logic               hit;
    logic [SYM_W-1:0]   hit_idx;
    logic               at_max;

    // Match evaluation works on the accumulator as it will look after the
    // current bit is shifted in, so a codeword is recognised on the very
    // cycle its last bit arrives. Only the low new_cnt bits take part in the
    // compare. An aborted load leaves table_ok low, which makes every entry
    // behave as length 0 (never matches). Scanning from the top index down
    // lets the lowest matching index win when the table is ambiguous.
    always_comb begin
        new_acc  = {acc[MAX_LEN-2:0], in_bit};
        new_cnt  = cnt + LEN_W'(1);
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i < int'(new_cnt)) begin
                len_mask[i] = 1'b1;
            end
        end
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = NSYM - 1; k >= 0; k--) begin
            if (table_ok && (len_tab[k] == new_cnt) &&
                (((code_tab[k] ^ new_acc) & len_mask) == '0)) begin
                hit     = 1'b1;
                hit_idx = SYM_W'(k);
            end
        end
        at_max = (new_cnt == LEN_W'(MAX_LEN));
    end

    // Single state machine holding the table, the shift accumulator and the
    // registered output pulses. Output pulses default to zero each cycle so
    // that they last exactly one cycle and out_sym is zero when not valid.
    // Reset wipes the table lengths as well, so a stale table can never
    // decode after a reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            load_cnt  <= '0;
            table_ok  <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_sym   <= '0;
            out_err   <= 1'b0;
            out_done  <= 1'b0;
            for (int k = 0; k < NSYM; k++) begin
                len_tab[k]  <= '0;
                code_tab[k] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            out_sym   <= '0;
            out_err   <= 1'b0;
            out_done  <= 1'b0;

            case (state)
                IDLE: begin
                    if (tbl_valid) begin
                        len_tab[0]  <= tbl_len;
                        code_tab[0] <= tbl_code;
                        load_cnt    <= SYM_W'(1);
                        table_ok    <= 1'b0;
                        state       <= LOAD;
                    end
                end

                LOAD: begin
                    if (tbl_valid) begin
                        len_tab[load_cnt]  <= tbl_len;
                        code_tab[load_cnt] <= tbl_code;
                        load_cnt           <= load_cnt + SYM_W'(1);
                        if (load_cnt == SYM_W'(NSYM - 1)) begin
                            table_ok <= 1'b1;
                            acc      <= '0;
                            cnt      <= '0;
                            load_cnt <= '0;
                            state    <= DECODE;
                        end
                    end else begin
                        table_ok <= 1'b0;
                        load_cnt <= '0;
                        state    <= IDLE;
                    end
                end

                DECODE: begin
                    if (in_valid) begin
                        if (hit) begin
                            out_valid <= 1'b1;
                            out_sym   <= hit_idx;
                            acc       <= '0;
                            cnt       <= '0;
                        end else if (at_max) begin
                            out_err <= 1'b1;
                            acc     <= '0;
                            cnt     <= '0;
                        end else begin
                            acc <= new_acc;
                            cnt <= new_cnt;
                        end

                        // A final bit that leaves a partial codeword flags
                        // an error; either way the stream ends here and a
                        // fresh table load is needed before decoding again.
                        if (in_last) begin
                            if (!hit) begin
                                out_err <= 1'b1;
                            end
                            out_done <= 1'b1;
                            acc      <= '0;
                            cnt      <= '0;
                            state    <= IDLE;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_huffman_decoder.sv
// ---------------------------------------------------------------------------
// tb_huffman_decoder
//
// Self-checking bench for huffman_decoder. Each driven bit that should
// produce an output pushes the expected output event (with the cycle it is
// due) onto a scoreboard queue; a monitor on the falling edge pops and
// compares it, and flags any output pulse that nothing expected.
// ---------------------------------------------------------------------------
module tb_huffman_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       tbl_valid;
    logic [2:0] tbl_len;
    logic [6:0] tbl_code;
    logic       in_valid;
    logic       in_bit;
    logic       in_last;
    logic       out_valid;
    logic [2:0] out_sym;
    logic       out_err;
    logic       out_done;

    typedef struct {
        int         due;
        logic [5:0] ev;
    } exp_t;

    exp_t       exp_q[$];
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    logic [2:0] t_len  [8];
    logic [6:0] t_code [8];

    huffman_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .tbl_valid (tbl_valid),
        .tbl_len   (tbl_len),
        .tbl_code  (tbl_code),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_sym   (out_sym),
        .out_err   (out_err),
        .out_done  (out_done)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Count rising edges so expectations can be tied to a specific cycle
    always @(posedge clk) cyc++;

    // Compare one observed value with its expected value and log mismatches
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Event encoding: {valid, err, done, sym}
    function automatic logic [5:0] evSym(input logic [2:0] s, input logic d);
        return {1'b1, 1'b0, d, s};
    endfunction

    function automatic logic [5:0] evErr(input logic d);
        return {1'b0, 1'b1, d, 3'b000};
    endfunction

    // Monitor: pop the scoreboard when an event is due, otherwise any pulse
    // on the outputs is spurious
    always @(negedge clk) begin
        logic [5:0] obs;
        exp_t       e;
        obs = {out_valid, out_err, out_done, out_sym};
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            checkOutput("event", 32'(obs), 32'(e.ev));
        end else if (obs !== 6'b0) begin
            checkOutput("spurious", 32'(obs), 32'h0);
        end
    end

    // Drive one serial bit; a nonzero ev is the output expected one cycle later
    task automatic applyStimulus(input logic b, input logic last, input logic [5:0] ev);
        exp_t e;
        @(negedge clk);
        in_valid  = 1'b1;
        in_bit    = b;
        in_last   = last;
        tbl_valid = 1'b0;
        if (ev != 6'b0) begin
            e.due = cyc + 1;
            e.ev  = ev;
            exp_q.push_back(e);
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid  = 1'b0;
            in_bit    = 1'b0;
            in_last   = 1'b0;
            tbl_valid = 1'b0;
        end
    endtask

    // Stream the first n entries of t_len/t_code, then drop tbl_valid
    task automatic loadTable(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid  = 1'b0;
            in_last   = 1'b0;
            tbl_valid = 1'b1;
            tbl_len   = t_len[i];
            tbl_code  = t_code[i];
        end
        idleCycles(1);
    endtask

    task automatic setTableT();
        t_len[0] = 3'd1; t_code[0] = 7'b0000000;
        t_len[1] = 3'd2; t_code[1] = 7'b0000010;
        t_len[2] = 3'd3; t_code[2] = 7'b0000110;
        t_len[3] = 3'd4; t_code[3] = 7'b0001110;
        t_len[4] = 3'd5; t_code[4] = 7'b0011110;
        t_len[5] = 3'd6; t_code[5] = 7'b0111110;
        t_len[6] = 3'd7; t_code[6] = 7'b1111110;
        t_len[7] = 3'd7; t_code[7] = 7'b1111111;
    endtask

    initial begin
        rst       = 1'b1;
        tbl_valid = 1'b1;
        tbl_len   = 3'd1;
        tbl_code  = 7'd0;
        in_valid  = 1'b1;
        in_bit    = 1'b0;
        in_last   = 1'b1;
        setTableT();

        // Reset held for two cycles with both strobes active
        repeat (2) begin
            @(negedge clk);
            checkOutput("in_reset", 32'({out_valid, out_err, out_done, out_sym}), 32'h0);
        end
        rst       = 1'b0;
        tbl_valid = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        @(negedge clk);
        checkOutput("post_reset", 32'({out_valid, out_err, out_done, out_sym}), 32'h0);
        applyStimulus(1'b0, 1'b1, 6'b0);
        idleCycles(3);

        // Table T, stream 0 10 110 1111111
        loadTable(8);
        applyStimulus(1'b0, 1'b0, evSym(3'd0, 1'b0));
        applyStimulus(1'b1, 1'b0, 6'b0);
        applyStimulus(1'b0, 1'b0, evSym(3'd1, 1'b0));
        applyStimulus(1'b1, 1'b0, 6'b0);
        applyStimulus(1'b1, 1'b0, 6'b0);
        applyStimulus(1'b0, 1'b0, evSym(3'd2, 1'b0));
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 6'b0);
        applyStimulus(1'b1, 1'b1, evSym(3'd7, 1'b1));
        idleCycles(3);

        // Table T, bits 1 1 1 0 with gaps, then 0 last
        loadTable(8);
        applyStimulus(1'b1, 1'b0, 6'b0); idleCycles(3);
        applyStimulus(1'b1, 1'b0, 6'b0); idleCycles(3);
        applyStimulus(1'b1, 1'b0, 6'b0); idleCycles(3);
        applyStimulus(1'b0, 1'b0, evSym(3'd3, 1'b0)); idleCycles(3);
        applyStimulus(1'b0, 1'b1, evSym(3'd0, 1'b1));
        idleCycles(3);

        // Entry 7 unassigned: 1111111 is undecodable, then 0 last
        t_len[7] = 3'd0;
        loadTable(8);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 6'b0);
        applyStimulus(1'b1, 1'b0, evErr(1'b0));
        applyStimulus(1'b0, 1'b1, evSym(3'd0, 1'b1));
        idleCycles(3);

        // Partial codeword at end of stream, later bits ignored
        setTableT();
        loadTable(8);
        applyStimulus(1'b1, 1'b0, 6'b0);
        applyStimulus(1'b1, 1'b1, evErr(1'b1));
        applyStimulus(1'b0, 1'b0, 6'b0);
        applyStimulus(1'b0, 1'b1, 6'b0);
        idleCycles(3);

        // Aborted load after 5 entries, stream ignored
        loadTable(5);
        applyStimulus(1'b0, 1'b0, 6'b0);
        applyStimulus(1'b0, 1'b1, 6'b0);
        idleCycles(3);

        // Reset in the middle of a codeword
        loadTable(8);
        applyStimulus(1'b1, 1'b0, 6'b0);
        applyStimulus(1'b1, 1'b0, 6'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b1, 6'b0);
        idleCycles(3);

        // Full reload decodes again
        loadTable(8);
        applyStimulus(1'b0, 1'b1, evSym(3'd0, 1'b1));
        idleCycles(5);

        checkOutput("drain", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/huffman_decoder.md
Name: huffman_decoder

Overview:
- Receiving end of the Huffman encoder's serial `out_code` stream.
- Loads an 8-entry codeword table (length + code per symbol), then accepts a serial MSB-first bitstream.
- Emits one decoded 3-bit symbol index per completed codeword.
- Sits downstream of the encoder in the codec loopback path, and is used to self-check encoder output in system tests.

Parameters:
- NSYM, 8, number of symbols / table entries
- SYM_W, 3, symbol index width
- MAX_LEN, 7, maximum codeword length in bits
- LEN_W, 3, width of codeword-length field

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- tbl_valid  input  1  table-load strobe; high for exactly NSYM consecutive cycles, entries in symbol order 0..7
- tbl_len  input  LEN_W  codeword length of current entry, legal 1..MAX_LEN
- tbl_code  input  MAX_LEN  codeword, right-aligned (LSB = last bit transmitted)
- in_valid  input  1  serial bit strobe
- in_bit  input  1  serial code bit, MSB of each codeword first
- in_last  input  1  qualifies final bit of the stream (meaningful only with in_valid)
- out_valid  output  1  one-cycle pulse: out_sym holds a decoded symbol
- out_sym  output  SYM_W  decoded symbol index
- out_err  output  1  one-cycle pulse: undecodable bits were discarded
- out_done  output  1  one-cycle pulse: stream finished, block back in IDLE

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE; load counter, accumulator and bit count are cleared; table contents are cleared to len=0 (entries never match).
  - All outputs are 0 the cycle after reset. Reset mid-load or mid-decode aborts immediately; no pending output is emitted.
- out_sym is 0 whenever out_valid is 0, which matches the codebase rule that output data is zero when not valid.
- State machine IDLE / LOAD / DECODE:
  - IDLE:
    - tbl_valid=1 writes entry 0 and moves to LOAD with count=1.
    - in_valid is ignored.
  - LOAD:
    - tbl_valid=1 writes entry[count] and increments count. When entry 7 is written, move to DECODE.
    - tbl_valid=0 before entry 7: abort to IDLE. The table is marked invalid, so all entries are treated as len=0 until the next full load.
    - in_valid is ignored.
  - DECODE:
    - tbl_valid is ignored.
    - Each cycle with in_valid=1: acc <= {acc[MAX_LEN-2:0], in_bit}; cnt <= cnt+1. Match evaluation uses the post-shift value, combinationally from the current bit.
    - Match rule: an entry k matches when tbl_len[k]==cnt+1 and tbl_code[k] equals the low cnt+1 bits of the new acc. If several entries match, the lowest index wins (illegal table, but deterministic).
    - Match: the next cycle has out_valid=1 and out_sym=k; acc and cnt are cleared. Latency is 1 cycle from the completing bit edge to the registered output.
    - No match and cnt+1==MAX_LEN: the next cycle has out_err=1; acc and cnt are cleared; decoding continues with the next bit.
    - in_last=1 with in_valid=1:
      - The bit is processed as above.
      - If it completes a match, out_valid fires. If it leaves a partial codeword (no match, cnt+1<MAX_LEN), out_err fires instead.
      - In the same cycle as that out_valid/out_err, out_done=1 and state goes to IDLE. The table is retained but a new load is required before decoding.
    - in_valid=0: no state change (bubbles are legal between any bits).
- out_valid and out_err are never high together.
- Back-to-back bits give at most one symbol per cycle; no backpressure.
- The table persists until reset or the next full load.

Test Plan:
- Reset check: assert rst for 2 cycles while tbl_valid=1 and in_valid=1 -> all outputs 0 the cycle after reset and during reset; state IDLE (a following in_valid bit produces no output).
- Load table T: (1,0),(2,10),(3,110),(4,1110),(5,11110),(6,111110),(7,1111110),(7,1111111). Stream "0 10 110 1111111" with in_last on the final bit -> out_sym 0,1,2,7, each 1 cycle after its completing bit; out_done high with symbol 7.
- Table T, bits "1 1 1 0" with 3 idle cycles inserted between bits, then "0" with in_last -> out_sym=3 after the 4th bit; out_sym=0 plus out_done after the last bit; no spurious pulses during the gaps.
- Table where 1111111 is unassigned (entry 7 len=0), stream "1111111 0" with in_last on the final 0 -> out_err after the 7th bit, then out_sym=0 plus out_done.
- Table T, stream "1 1" with in_last on the 2nd bit -> out_err and out_done together, no out_valid; the next in_valid bits are ignored until a new load.
- Abort cases:
  - Drop tbl_valid after 5 entries, then try to stream -> bits ignored, no output.
  - Assert rst mid-stream after "11" -> no output, IDLE.
  - A full reload then decodes "0" -> sym 0.
